// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_ctrl_pkg
// Brief   : Shared state encoding, push-button indices and ALU opcodes.
// Rev     : 1.0
// ============================================================================
package alu_ctrl_pkg;

    // Encoding is exported on state_dbg, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int c_pb_load_a = 1;
    localparam int c_pb_load_b = 2;
    localparam int c_pb_exec   = 3;

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_mul = 4'd5;

endpackage
`default_nettype wire

// File: rtl/alu_wdog_counter.sv
`default_nettype none
// ============================================================================
// Module : alu_wdog_counter
// Brief  : Clear/enable watchdog that saturates at TIMEOUT-1 and flags it.
// Rev    : 1.0
// ============================================================================
module alu_wdog_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int              c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Holding at the terminal value keeps the counter from ever wrapping.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign terminal = (r_count == c_term);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Front-panel load-A / load-B / execute sequencer with ALU watchdog.
// Rev    : 1.0
// ============================================================================
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_pulse,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:1]       pb,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       state_dbg
);

    state_t           r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_alu_start;
    logic [RES_W-1:0] r_result;
    logic             r_result_valid;
    logic             r_busy;
    logic             r_timeout_err;

    logic w_cmd;
    logic w_wdog_clear;
    logic w_wdog_en;
    logic w_wdog_term;

    // A switch-only edge produces run_pulse with no button set; that is not a command.
    assign w_cmd        = run_pulse && (|pb);
    assign w_wdog_clear = (r_state == ST_ISSUE);
    assign w_wdog_en    = (r_state == ST_WAIT) && !alu_done;

    alu_wdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear    (w_wdog_clear),
        .enable   (w_wdog_en),
        .terminal (w_wdog_term)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_alu_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_cmd) begin
                        r_result_valid <= 1'b0;
                        if (pb[c_pb_exec]) begin
                            r_alu_op    <= 4'(sw);
                            r_alu_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else if (pb[c_pb_load_b]) begin
                            r_alu_b <= sw;
                            r_state <= ST_IDLE;
                        end else begin
                            r_alu_a <= sw;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the terminal watchdog cycle still counts as success.
                    if (alu_done) begin
                        r_result       <= alu_result;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_DONE;
                    end else if (w_wdog_term) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (w_cmd) begin
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign alu_start    = r_alu_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;
    assign state_dbg    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Directed plus randomized bench for alu_op_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_alu_op_sequencer;
    import alu_ctrl_pkg::*;

    localparam int c_width   = 4;
    localparam int c_res_w   = 8;
    localparam int c_timeout = 15;

    logic               clk_in;
    logic               rst_n;
    logic               run_pulse;
    logic [c_width-1:0] sw;
    logic [3:1]         pb;
    logic               alu_done;
    logic [c_res_w-1:0] alu_result;
    wire  [c_width-1:0] alu_a;
    wire  [c_width-1:0] alu_b;
    wire  [3:0]         alu_op;
    wire                alu_start;
    wire  [c_res_w-1:0] result;
    wire                result_valid;
    wire                busy;
    wire                timeout_err;
    wire  [2:0]         state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: front-panel state as seen by an operator.
    logic [3:0] m_a, m_b, m_op;
    logic [7:0] m_result;
    logic       m_valid, m_err;
    logic [2:0] e_state;

    alu_op_sequencer #(
        .WIDTH   (c_width),
        .RES_W   (c_res_w),
        .TIMEOUT (c_timeout)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .run_pulse    (run_pulse),
        .sw           (sw),
        .pb           (pb),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
        case (op)
            c_op_add: return 8'(a) + 8'(b);
            c_op_sub: return 8'(a) - 8'(b);
            c_op_and: return 8'(a & b);
            c_op_or:  return 8'(a | b);
            c_op_xor: return 8'(a ^ b);
            c_op_mul: return 8'(a) * 8'(b);
            default:  return {b, a};
        endcase
    endfunction

    task automatic model_reset();
        m_a = '0; m_b = '0; m_op = '0; m_result = '0;
        m_valid = 1'b0; m_err = 1'b0; e_state = 3'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu_a"},   32'(alu_a),        32'(m_a));
        chk({tag, ".alu_b"},   32'(alu_b),        32'(m_b));
        chk({tag, ".alu_op"},  32'(alu_op),       32'(m_op));
        chk({tag, ".result"},  32'(result),       32'(m_result));
        chk({tag, ".valid"},   32'(result_valid), 32'(m_valid));
        chk({tag, ".tmo_err"}, 32'(timeout_err),  32'(m_err));
        chk({tag, ".busy"},    32'(busy),         32'(e_state == 3'd1 || e_state == 3'd2));
        chk({tag, ".start"},   32'(alu_start),    32'(e_state == 3'd1));
        chk({tag, ".state"},   32'(state_dbg),    32'(e_state));
    endtask

    // One run_pulse with the given buttons; model applies the operator-level rules.
    task automatic send(input logic [3:1] p, input logic [3:0] s);
        run_pulse = 1'b1; pb = p; sw = s;
        tick();
        run_pulse = 1'b0; pb = '0;
        if (p != 3'b000) begin
            if (m_err) begin
                m_err = 1'b0; e_state = 3'd0;
            end else if (p[3]) begin
                m_op = s; m_valid = 1'b0; e_state = 3'd1;
            end else if (p[2]) begin
                m_b = s; m_valid = 1'b0; e_state = 3'd0;
            end else begin
                m_a = s; m_valid = 1'b0; e_state = 3'd0;
            end
        end else if (e_state == 3'd3) begin
            e_state = 3'd0;
        end
    endtask

    // Execute, with the ALU answering in WAIT cycle d (d > TIMEOUT means never).
    task automatic run_exec(input logic [3:1] p, input logic [3:0] s, input int d,
                            input bit stray, input bit drop);
        logic [7:0] exp;
        send(p, s);
        check_all("exec_cmd");
        if (e_state != 3'd1) return;
        exp = alu_ref(m_a, m_b, m_op);
        if (stray) begin
            alu_done = 1'b1; alu_result = 8'hEE;
        end
        tick();
        alu_done = 1'b0;
        e_state = 3'd2;
        check_all("wait_entry");
        for (int k = 1; k <= c_timeout; k++) begin
            if (k == d) begin
                alu_done = 1'b1; alu_result = exp;
            end else if (drop && k == 1) begin
                run_pulse = 1'b1; pb = 3'b001; sw = ~m_a;
            end
            tick();
            alu_done = 1'b0; run_pulse = 1'b0; pb = '0; alu_result = 8'($urandom);
            if (k == d) break;
            if (k < c_timeout) check_all($sformatf("wait_k%0d", k));
        end
        if (d <= c_timeout) begin
            m_result = exp; m_valid = 1'b1; e_state = 3'd3;
        end else begin
            m_err = 1'b1; e_state = 3'd4;
        end
        check_all("exec_end");
    endtask

    initial begin
        int sel;
        int d;
        rst_n = 1'b0; run_pulse = 1'b0; sw = '0; pb = '0;
        alu_done = 1'b0; alu_result = '0;
        model_reset();
        repeat (2) tick();
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // Load 3 and 5, ADD, ALU answers two cycles after start.
        send(3'b001, 4'd3);
        check_all("load_a");
        send(3'b010, 4'd5);
        check_all("load_b");
        run_exec(3'b100, c_op_add, 2, 1'b0, 1'b0);
        chk("add_result", 32'(result), 32'd8);
        tick();
        e_state = 3'd0;
        check_all("done_to_idle");

        // All buttons at once: execute wins; a load during WAIT is dropped.
        run_exec(3'b111, 4'd6, 3, 1'b0, 1'b1);

        // Watchdog expiry, then recovery consumes one command.
        run_exec(3'b100, c_op_mul, c_timeout + 1, 1'b0, 1'b0);
        send(3'b010, 4'd9);
        check_all("err_recover");
        run_exec(3'b100, c_op_sub, c_timeout, 1'b1, 1'b0);

        // Switch noise and stray completions in IDLE.
        for (int i = 0; i < 4; i++) begin
            send(3'b000, 4'($urandom));
            check_all("noise");
        end
        alu_done = 1'b1; alu_result = 8'h5A;
        tick();
        alu_done = 1'b0;
        check_all("stray_done_idle");

        // Randomized operator sessions.
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 1) begin
                send(3'b001, 4'($urandom));
                check_all("rnd_load_a");
            end else if (sel <= 3) begin
                send(3'b010, 4'($urandom));
                check_all("rnd_load_b");
            end else if (sel <= 7) begin
                if ($urandom_range(0, 3) == 0) d = int'($urandom_range(c_timeout - 1, c_timeout + 1));
                else d = int'($urandom_range(1, 5));
                run_exec({1'b1, 2'($urandom)}, 4'($urandom_range(0, 7)), d,
                         1'($urandom), 1'($urandom));
            end else if (sel == 8) begin
                send(3'b000, 4'($urandom));
                check_all("rnd_noise");
            end else begin
                alu_done = 1'b1; alu_result = 8'($urandom);
                tick();
                alu_done = 1'b0;
                if (e_state == 3'd3) e_state = 3'd0;
                check_all("rnd_stray");
            end
        end

        // Asynchronous reset in the middle of WAIT, then a late completion.
        if (m_err) begin
            send(3'b001, 4'd0);
        end
        run_pulse = 1'b1; pb = 3'b100; sw = c_op_add;
        tick();
        run_pulse = 1'b0; pb = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("rst_mid_wait");
        tick();
        rst_n = 1'b1;
        alu_done = 1'b1; alu_result = 8'hAA;
        tick();
        alu_done = 1'b0;
        check_all("late_done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
